// File: rtl/vid_meter_pkg.sv
// Shared types and constants for the video frame meter.
package vid_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } meter_state_t;

  // Width of each half of res_word / total_word.
  localparam int unsigned FIELD_W = 16;

  // status_word bit positions.
  localparam int unsigned STAT_MATCH_LSB  = 0;
  localparam int unsigned STAT_STATE_LSB  = 4;
  localparam int unsigned STAT_LOCKED_BIT = 6;
  localparam int unsigned STAT_OVF_BIT    = 7;

  function automatic logic [31:0] pack_pair(input logic [FIELD_W-1:0] hi,
                                            input logic [FIELD_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/vid_edge_det.sv
// Rising-edge detector: registers the previous level, flags high-after-low.
module vid_edge_det (
  input  logic ps_clk,
  input  logic rstn,
  input  logic sig,
  output logic rise
);

  logic prev;

  // Previous-cycle level of the input
  always_ff @(posedge ps_clk) begin
    if (!rstn) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/vid_frame_meter.sv
// Video frame meter: passes video through one register stage and measures
// active/total line and frame geometry, locking after repeated identical frames.
module vid_frame_meter #(
  parameter int unsigned CNT_WIDTH      = 12,
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic        PixelClk,
  input  logic        vid_rstn,
  input  logic        vid_in_hsync,
  input  logic        vid_in_vsync,
  input  logic        vid_in_VDE,
  input  logic [23:0] vid_in_data,
  output logic        vid_out_hsync,
  output logic        vid_out_vsync,
  output logic        vid_out_VDE,
  output logic [23:0] vid_out_data,
  input  logic        clr_err,
  output logic [31:0] res_word,
  output logic [31:0] total_word,
  output logic [31:0] frame_cnt,
  output logic [31:0] status_word
);
  import vid_meter_pkg::*;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t            CNT_MAX = '1;
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  meter_state_t    state, state_n;
  logic [3:0]      match_cnt, match_n;
  logic            ovf;
  logic            hs_rise, vs_rise;
  logic            timeout, frame_end, sat, same;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     res_n, total_n;
  cnt_t            h_cnt, de_cnt, vl_cnt, va_cnt, h_line, h_act;
  cnt_t            h_cnt_n, de_cnt_n, vl_cnt_n, va_cnt_n, h_line_n, h_act_n;

  vid_edge_det u_hs_det (.ps_clk(PixelClk), .rstn(vid_rstn), .sig(vid_in_hsync), .rise(hs_rise));
  vid_edge_det u_vs_det (.ps_clk(PixelClk), .rstn(vid_rstn), .sig(vid_in_vsync), .rise(vs_rise));

  // One-stage video pass-through
  always_ff @(posedge PixelClk) begin
    if (!vid_rstn) begin
      vid_out_hsync <= 1'b0;
      vid_out_vsync <= 1'b0;
      vid_out_VDE   <= 1'b0;
      vid_out_data  <= '0;
    end else begin
      vid_out_hsync <= vid_in_hsync;
      vid_out_vsync <= vid_in_vsync;
      vid_out_VDE   <= vid_in_VDE;
      vid_out_data  <= vid_in_data;
    end
  end

  assign timeout   = (state != ST_IDLE) && (to_cnt == TO_LAST);
  assign frame_end = (state != ST_IDLE) && vs_rise && !timeout;

  // Counter next values; a coincident hsync rise closes the line before the
  // frame is sampled, so the frame results come from the post-line values.
  always_comb begin
    h_cnt_n  = h_cnt;
    de_cnt_n = de_cnt;
    vl_cnt_n = vl_cnt;
    va_cnt_n = va_cnt;
    h_line_n = h_line;
    h_act_n  = h_act;
    sat      = 1'b0;
    if (state == ST_IDLE) begin
      h_cnt_n  = '0;
      de_cnt_n = '0;
      vl_cnt_n = '0;
      va_cnt_n = '0;
      h_line_n = '0;
      h_act_n  = '0;
      if (vs_rise) begin
        h_cnt_n  = cnt_t'(1);
        de_cnt_n = cnt_t'(vid_in_VDE);
      end
    end else if (hs_rise) begin
      h_line_n = h_cnt;
      h_cnt_n  = cnt_t'(1);
      // the rise cycle itself starts the next line's pixel count
      de_cnt_n = cnt_t'(vid_in_VDE);
      if (de_cnt != '0) begin
        if (de_cnt > h_act) h_act_n = de_cnt;
        if (va_cnt == CNT_MAX) sat = 1'b1;
        else                   va_cnt_n = va_cnt + cnt_t'(1);
      end
      if (vl_cnt == CNT_MAX) sat = 1'b1;
      else                   vl_cnt_n = vl_cnt + cnt_t'(1);
    end else begin
      if (h_cnt == CNT_MAX) sat = 1'b1;
      else                  h_cnt_n = h_cnt + cnt_t'(1);
      if (vid_in_VDE) begin
        if (de_cnt == CNT_MAX) sat = 1'b1;
        else                   de_cnt_n = de_cnt + cnt_t'(1);
      end
    end
    res_n   = pack_pair(FIELD_W'(va_cnt_n), FIELD_W'(h_act_n));
    total_n = pack_pair(FIELD_W'(vl_cnt_n), FIELD_W'(h_line_n));
    same    = (res_n == res_word) && (total_n == total_word);
    if (frame_end) begin
      vl_cnt_n = '0;
      va_cnt_n = '0;
      h_act_n  = '0;
    end
  end

  // Next state and match count
  always_comb begin
    state_n = state;
    match_n = match_cnt;
    if (state == ST_IDLE) begin
      match_n = '0;
      if (vs_rise) state_n = ST_MEASURE;
    end else if (timeout) begin
      state_n = ST_IDLE;
      match_n = '0;
    end else if (frame_end) begin
      if (same) begin
        match_n = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
        state_n = ({28'd0, match_n} >= STABLE_FRAMES) ? ST_LOCKED : ST_MEASURE;
      end else begin
        match_n = '0;
        state_n = ST_MEASURE;
      end
    end
  end

  // State register
  always_ff @(posedge PixelClk) begin
    if (!vid_rstn) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
    end
  end

  // Measurement counters, timeout counter, sticky overflow and result words
  always_ff @(posedge PixelClk) begin
    if (!vid_rstn) begin
      h_cnt      <= '0;
      de_cnt     <= '0;
      vl_cnt     <= '0;
      va_cnt     <= '0;
      h_line     <= '0;
      h_act      <= '0;
      to_cnt     <= '0;
      ovf        <= 1'b0;
      res_word   <= '0;
      total_word <= '0;
      frame_cnt  <= '0;
    end else begin
      h_cnt  <= h_cnt_n;
      de_cnt <= de_cnt_n;
      vl_cnt <= vl_cnt_n;
      va_cnt <= va_cnt_n;
      h_line <= h_line_n;
      h_act  <= h_act_n;
      if (state == ST_IDLE || vs_rise || timeout) to_cnt <= '0;
      else                                        to_cnt <= to_cnt + 1'b1;
      ovf <= (ovf & ~clr_err) | sat;
      if (frame_end) begin
        res_word   <= res_n;
        total_word <= total_n;
        frame_cnt  <= frame_cnt + 32'd1;
      end
    end
  end

  // Status word assembled straight from registers
  always_comb begin
    status_word                           = '0;
    status_word[STAT_MATCH_LSB +: 4]      = match_cnt;
    status_word[STAT_STATE_LSB +: 2]      = state;
    status_word[STAT_LOCKED_BIT]          = (state == ST_LOCKED);
    status_word[STAT_OVF_BIT]             = ovf;
  end

endmodule

// File: tb/tb_vid_frame_meter.sv
// Bench for vid_frame_meter: directed geometry scenarios plus random video,
// every cycle compared against a line/frame-level model of the meter.
module tb_vid_frame_meter;

  logic        PixelClk;
  logic        rstn;
  logic        hs, vs, de, clr;
  logic [23:0] data;

  logic        ohs12, ovs12, ode12, ohs8, ovs8, ode8;
  logic [23:0] od12, od8;
  logic [31:0] res12, tot12, fc12, st12, res8, tot8, fc8, st8;

  int checks   = 0;
  int failures = 0;

  vid_frame_meter #(.CNT_WIDTH(12), .STABLE_FRAMES(2), .TIMEOUT_CYCLES(100)) dut (
    .PixelClk(PixelClk), .vid_rstn(rstn),
    .vid_in_hsync(hs), .vid_in_vsync(vs), .vid_in_VDE(de), .vid_in_data(data),
    .vid_out_hsync(ohs12), .vid_out_vsync(ovs12), .vid_out_VDE(ode12), .vid_out_data(od12),
    .clr_err(clr), .res_word(res12), .total_word(tot12), .frame_cnt(fc12), .status_word(st12)
  );

  vid_frame_meter #(.CNT_WIDTH(8), .STABLE_FRAMES(2), .TIMEOUT_CYCLES(4000000)) dut8 (
    .PixelClk(PixelClk), .vid_rstn(rstn),
    .vid_in_hsync(hs), .vid_in_vsync(vs), .vid_in_VDE(de), .vid_in_data(data),
    .vid_out_hsync(ohs8), .vid_out_vsync(ovs8), .vid_out_VDE(ode8), .vid_out_data(od8),
    .clr_err(clr), .res_word(res8), .total_word(tot8), .frame_cnt(fc8), .status_word(st8)
  );

  initial PixelClk = 1'b0;
  always #5 PixelClk = ~PixelClk;

  // Model: raw (unbounded) counts, clipped to the counter range when reported.
  typedef struct {
    int          st;      // 0 idle, 1 measure, 2 locked
    int          h_raw, de_raw, lines, al, hmax, hline, since, match;
    bit          ovf, phs, pvs;
    logic [31:0] res, tot, fcnt;
    logic        ohs, ovs, ode;
    logic [23:0] odata;
  } mdl_t;

  mdl_t m12, m8;

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic mdl_t mstep(input mdl_t mi, input bit rst_n, input bit h, input bit v,
                                 input bit e, input logic [23:0] d, input bit c,
                                 input int cw, input int tmo, input int stable);
    mdl_t m;
    int mx;
    bit hr, vr, sat;
    logic [31:0] nres, ntot;
    m = mi;
    mx = (1 << cw) - 1;
    sat = 1'b0;
    if (!rst_n) begin
      m = '{default: 0};
      return m;
    end
    hr = h && !m.phs;
    vr = v && !m.pvs;
    m.phs = h; m.pvs = v;
    m.ohs = h; m.ovs = v; m.ode = e; m.odata = d;
    if (m.st == 0) begin
      m.h_raw = 0; m.de_raw = 0; m.lines = 0; m.al = 0; m.hmax = 0;
      m.hline = 0; m.since = 0; m.match = 0;
      if (vr) begin
        m.st = 1; m.h_raw = 1; m.de_raw = int'(e);
      end
    end else begin
      if (hr) begin
        m.hline = clip(m.h_raw, mx);
        if (m.de_raw > 0) begin
          if (clip(m.de_raw, mx) > m.hmax) m.hmax = clip(m.de_raw, mx);
          m.al++;
          if (m.al > mx) sat = 1'b1;
        end
        m.lines++;
        if (m.lines > mx) sat = 1'b1;
        m.h_raw = 1;
        m.de_raw = int'(e);
      end else begin
        m.h_raw++;
        if (m.h_raw > mx) sat = 1'b1;
        if (e) begin
          m.de_raw++;
          if (m.de_raw > mx) sat = 1'b1;
        end
      end
      if (m.since + 1 >= tmo) begin
        m.st = 0; m.match = 0; m.since = 0;
      end else if (vr) begin
        nres = {16'(clip(m.al, mx)), 16'(m.hmax)};
        ntot = {16'(clip(m.lines, mx)), 16'(m.hline)};
        if (nres == m.res && ntot == m.tot) begin
          m.match = (m.match >= 15) ? 15 : m.match + 1;
          m.st = (m.match >= stable) ? 2 : 1;
        end else begin
          m.match = 0;
          m.st = 1;
        end
        m.res = nres; m.tot = ntot; m.fcnt = m.fcnt + 32'd1;
        m.lines = 0; m.al = 0; m.hmax = 0; m.since = 0;
      end else begin
        m.since++;
      end
    end
    m.ovf = sat || (m.ovf && !c);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input logic oh, input logic ov,
                         input logic oe, input logic [23:0] od, input logic [31:0] rw,
                         input logic [31:0] tw, input logic [31:0] fc, input logic [31:0] sw);
    logic [31:0] exp_st;
    exp_st = {24'd0, m.ovf, (m.st == 2), 2'(m.st), 4'(m.match)};
    chk({tag, ".out_hsync"}, 32'(oh), 32'(m.ohs));
    chk({tag, ".out_vsync"}, 32'(ov), 32'(m.ovs));
    chk({tag, ".out_VDE"},   32'(oe), 32'(m.ode));
    chk({tag, ".out_data"},  32'(od), 32'(m.odata));
    chk({tag, ".res_word"},  rw, m.res);
    chk({tag, ".total_word"}, tw, m.tot);
    chk({tag, ".frame_cnt"}, fc, m.fcnt);
    chk({tag, ".status_word"}, sw, exp_st);
  endtask

  // Cycle compare: advance both models on each edge, compare just after it
  always @(posedge PixelClk) begin
    m12 = mstep(m12, rstn, hs, vs, de, data, clr, 12, 100, 2);
    m8  = mstep(m8,  rstn, hs, vs, de, data, clr, 8, 4000000, 2);
    #1;
    cmp_dut("w12", m12, ohs12, ovs12, ode12, od12, res12, tot12, fc12, st12);
    cmp_dut("w8",  m8,  ohs8,  ovs8,  ode8,  od8,  res8,  tot8,  fc8,  st8);
  end

  task automatic drive(input bit h, input bit v, input bit e, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PixelClk);
      hs = h; vs = v; de = e; data = 24'($urandom); clr = 1'b0;
    end
  endtask

  // One frame: hsync 2 cycles at line start, vsync on lines 0-1,
  // active pixels on lines 1..va starting at column 2.
  task automatic send_frame(input int ha, input int ht, input int va, input int vt, input int nl);
    for (int l = 0; l < nl; l++) begin
      for (int c = 0; c < ht; c++) begin
        @(negedge PixelClk);
        hs   = (c < 2);
        vs   = (l < 2);
        de   = (l >= 1) && (l <= va) && (c >= 2) && (c < 2 + ha);
        data = 24'($urandom);
        clr  = ($urandom_range(0, 127) == 0);
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge PixelClk);
    rstn = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; clr = 1'b0; data = 24'($urandom);
    repeat (n) @(negedge PixelClk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; clr = 1'b0; data = '0;
    repeat (3) @(negedge PixelClk);
    chk("rst_res", res12, 32'h0);
    chk("rst_total", tot12, 32'h0);
    chk("rst_fcnt", fc12, 32'h0);
    chk("rst_status", st12, 32'h0);
    rstn = 1'b1;

    // Stable 12x6 frame with 8x4 active
    repeat (3) send_frame(8, 12, 4, 6, 6);
    chk("f3_res", res12, 32'h0004_0008);
    chk("f3_total", tot12, 32'h0006_000C);
    chk("f3_status", st12, 32'h0000_0011);
    chk("f3_fcnt", fc12, 32'd2);
    send_frame(8, 12, 4, 6, 6);
    chk("f4_status_locked", st12, 32'h0000_0062);
    chk("f4_fcnt", fc12, 32'd3);

    // One frame narrower by a pixel breaks lock
    send_frame(8, 12, 4, 6, 6);
    send_frame(7, 12, 4, 6, 6);
    send_frame(8, 12, 4, 6, 6);
    chk("unlock_status", st12, 32'h0000_0010);
    chk("unlock_res", res12, 32'h0004_0007);
    chk("unlock_fcnt", fc12, 32'd6);

    // Vsync stops: timeout back to idle, results kept
    drive(0, 0, 0, 120);
    chk("tmo_status", st12, 32'h0000_0000);
    chk("tmo_res", res12, 32'h0004_0007);
    chk("tmo_total", tot12, 32'h0006_000C);

    // 300-cycle line on the 8-bit meter saturates h_total
    do_reset(2);
    drive(1, 1, 0, 2);
    drive(0, 0, 0, 298);
    drive(1, 1, 0, 2);
    drive(0, 0, 0, 3);
    chk("sat_htotal", {16'd0, tot8[15:0]}, 32'h0000_00FF);
    chk("sat_vtotal", {16'd0, tot8[31:16]}, 32'h0000_0001);
    chk("sat_ovf_set", 32'(st8[7]), 32'd1);
    @(negedge PixelClk); clr = 1'b1;
    @(negedge PixelClk); clr = 1'b0;
    chk("sat_ovf_clr", 32'(st8[7]), 32'd0);

    // Reset in the middle of a frame
    do_reset(1);
    repeat (3) send_frame(8, 12, 4, 6, 6);
    send_frame(8, 12, 4, 6, 3);
    @(negedge PixelClk);
    rstn = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; clr = 1'b0; data = 24'($urandom);
    @(negedge PixelClk);
    chk("mid_rst_res", res12, 32'h0);
    chk("mid_rst_total", tot12, 32'h0);
    chk("mid_rst_fcnt", fc12, 32'h0);
    chk("mid_rst_status", st12, 32'h0);
    chk("mid_rst_vout", {7'd0, ohs12, ovs12, ode12, od12}, 32'h0);
    rstn = 1'b1;
    send_frame(8, 12, 4, 6, 6);
    chk("post_rst_first_fcnt", fc12, 32'd0);
    send_frame(8, 12, 4, 6, 6);
    chk("post_rst_second_fcnt", fc12, 32'd1);
    chk("post_rst_second_res", res12, 32'h0004_0008);

    // Random geometries, each repeated a random number of times
    for (int f = 0; f < 25; f++) begin
      int ht, ha, vt, va, rep;
      ht  = $urandom_range(6, 20);
      ha  = $urandom_range(1, ht - 3);
      vt  = $urandom_range(3, 8);
      va  = $urandom_range(1, vt - 1);
      rep = $urandom_range(1, 5);
      for (int r = 0; r < rep; r++) send_frame(ha, ht, va, vt, vt);
    end

    // Unstructured random video
    for (int i = 0; i < 400; i++) begin
      @(negedge PixelClk);
      hs   = ($urandom_range(0, 3) == 0);
      vs   = ($urandom_range(0, 15) == 0);
      de   = 1'($urandom);
      data = 24'($urandom);
      clr  = ($urandom_range(0, 31) == 0);
    end

    drive(0, 0, 0, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vid_frame_meter.md
VID_FRAME_METER -- requirements
Module: vid_frame_meter

Interface
REQ-001 Parameter CNT_WIDTH, default 12: width of all pixel/line counters; supported range 8..16.
REQ-002 Parameter STABLE_FRAMES, default 2: consecutive identical frames required to assert locked; supported range 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 4000000: PixelClk cycles without a vsync rise before returning to IDLE.
REQ-004 PixelClk  in  1  sole clock; all logic on its rising edge.
REQ-005 vid_rstn  in  1  reset; synchronous, active-low.
REQ-006 vid_in_hsync, vid_in_vsync, vid_in_VDE  in  1 each  upstream video timing, active-high.
REQ-007 vid_in_data  in  24  upstream pixel data.
REQ-008 vid_out_hsync, vid_out_vsync, vid_out_VDE  out  1 each  registered pass-through timing.
REQ-009 vid_out_data  out  24  registered pass-through data.
REQ-010 clr_err  in  1  single-cycle pulse that clears the sticky overflow flag.
REQ-011 res_word  out  32  {zero-extended v_active[15:0], zero-extended h_active[15:0]}.
REQ-012 total_word  out  32  {zero-extended v_total[15:0], zero-extended h_total[15:0]}.
REQ-013 frame_cnt  out  32  number of completed frames since reset.
REQ-014 status_word  out  32  {24'd0, ovf, locked, state[1:0], match_cnt[3:0]}.

Function
REQ-015 Pass-through: each vid_out_* equals the corresponding vid_in_* delayed by exactly 1 cycle.
REQ-016 Edge detect: hsync rise / vsync rise = input high this cycle and low the previous cycle; registered previous values reset to 0.
REQ-017 h_cnt: increments every cycle; on hsync rise it is latched as line h_total and restarted at 1.
REQ-018 de_cnt: increments on VDE high; on hsync rise, the maximum nonzero de_cnt of the frame is retained as h_active, de_cnt cleared.
REQ-019 Line counters: on hsync rise, vl_cnt increments and va_cnt increments if de_cnt was nonzero for the finished line.
REQ-020 Simultaneous hsync and vsync rise: the line closes first, then the frame closes; both in the same cycle.
REQ-021 Every counter saturates at 2^CNT_WIDTH-1; saturation sets the sticky ovf flag.
REQ-022 ovf clears only on clr_err; a clr_err and a saturation in the same cycle leave ovf = 1.
REQ-023 States: IDLE, MEASURE, LOCKED; encoding 0, 1, 2.
REQ-024 IDLE: counters held cleared; first vsync rise -> MEASURE, no results latched.
REQ-025 MEASURE/LOCKED on vsync rise: latch h_active, v_active (va_cnt), h_total, v_total (vl_cnt) into output words, increment frame_cnt (wrapping at 2^32), clear per-frame counters.
REQ-026 Latched set equal to previous latched set: match_cnt increments (saturating at 15); at match_cnt = STABLE_FRAMES, go to LOCKED.
REQ-027 Latched set differs: match_cnt = 0, state -> MEASURE.
REQ-028 Timeout: vsync-rise spacing reaching TIMEOUT_CYCLES in MEASURE or LOCKED -> IDLE, match_cnt = 0; result words retain their last values.
REQ-029 locked = 1 only in LOCKED; all outputs registered, updated the cycle after the triggering edge.

Reset
REQ-030 On vid_rstn = 0 at a clock edge: all outputs, counters, and the timeout counter reset to 0; state = IDLE.
REQ-031 Reset asserted mid-frame aborts measurement with no partial latch; the first frame after reset is never reported.

Structure
REQ-032 Shared package vid_meter_pkg holds the state enum, the status_word bit-position constants, and the 16-bit field pack width.
REQ-033 One sub-module, vid_edge_det (registered rise detector), instantiated for hsync and vsync; all other logic is flat.

Verification
REQ-034 Frame h_total = 12, h_active = 8, v_total = 6, v_active = 4, repeated 4 frames -> after 3rd vsync rise res_word = 0x0004_0008, total_word = 0x0006_000C, and locked = 1 after the 4th vsync rise.
REQ-035 Locked stream, then one frame with h_active = 7 -> locked = 0, match_cnt = 0, state = MEASURE, res_word low half = 7.
REQ-036 CNT_WIDTH = 8, line of 300 cycles -> h_total = 255, ovf = 1; clr_err pulse -> ovf = 0.
REQ-037 Vsync stopped for TIMEOUT_CYCLES (set to 100) -> state = IDLE, locked = 0, res_word unchanged.
REQ-038 Reset asserted at line 3 of a frame -> all outputs 0 next cycle; the next report appears only after two further vsync rises.
REQ-039 Random video input -> vid_out_* equals vid_in_* delayed 1 cycle every cycle (scoreboard).
